// File: rtl/contadores_palabras.sv
// Per-FIFO popped-word counters with a 1-cycle count-read responder.
// Optional: define COUNTER_SATURATE_EN to saturate counters at 2^CNT_W-1.
module contadores_palabras #(
  parameter int FIFO_UNITS = 4,
  parameter int INDEX      = 2,
  parameter int CNT_W      = 5,
  parameter int TOT_W      = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  idle,
  input  logic [FIFO_UNITS-1:0] pop,
  input  logic [FIFO_UNITS-1:0] empty,
  input  logic                  req,
  input  logic [INDEX-1:0]      idx,
  output logic                  valid,
  output logic [CNT_W-1:0]      cuenta,
  output logic [TOT_W-1:0]      contador_4
);

`ifdef COUNTER_SATURATE_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
`endif

  logic [CNT_W-1:0]      cnt_q [FIFO_UNITS];
  logic [CNT_W-1:0]      cnt_d [FIFO_UNITS];
  logic [TOT_W-1:0]      tot_q, tot_d;
  logic                  valid_q, valid_d;
  logic [CNT_W-1:0]      cuenta_q, cuenta_d;
  logic [FIFO_UNITS-1:0] eff;
  logic [TOT_W-1:0]      inc;

  // Next-state: counted pops, running total and read capture
  always_comb begin
    eff      = '0;
    inc      = '0;
    valid_d  = req & idle & ~init;
    cuenta_d = valid_d ? cnt_q[idx] : cuenta_q;
    for (int i = 0; i < FIFO_UNITS; i++) begin
      eff[i] = pop[i] & ~empty[i] & ~init;
`ifdef COUNTER_SATURATE_EN
      // A saturated counter drops the increment so the total stays exact
      eff[i] = eff[i] & (cnt_q[i] != CNT_MAX);
`endif
      cnt_d[i] = init ? '0 : cnt_q[i] + CNT_W'(eff[i]);
      inc      = inc + TOT_W'(eff[i]);
    end
    tot_d = init ? '0 : tot_q + inc;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_UNITS; i++) cnt_q[i] <= '0;
      tot_q    <= '0;
      valid_q  <= 1'b0;
      cuenta_q <= '0;
    end else begin
      for (int i = 0; i < FIFO_UNITS; i++) cnt_q[i] <= cnt_d[i];
      tot_q    <= tot_d;
      valid_q  <= valid_d;
      cuenta_q <= cuenta_d;
    end
  end

  assign valid      = valid_q;
  assign cuenta     = cuenta_q;
  assign contador_4 = tot_q;

endmodule
